// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath (master) and the
// stall/flush sequencer (slave).
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [3:0]       id_srcReg1;
  logic [3:0]       id_srcReg2;
  logic             id_uses_src1;
  logic             id_uses_src2;
  logic             id_hlt;
  logic [3:0]       ex_dstReg;
  logic             ex_memRead;
  logic             ex_br_taken;
  logic             mem_busy;
  logic             pc_wen;
  logic             if_id_wen;
  logic             id_ex_wen;
  logic             ex_mem_wen;
  logic             mem_wb_wen;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic             halted;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output id_srcReg1, id_srcReg2, id_uses_src1, id_uses_src2, id_hlt,
           ex_dstReg, ex_memRead, ex_br_taken, mem_busy,
    input  pc_wen, if_id_wen, id_ex_wen, ex_mem_wen, mem_wb_wen,
           if_id_flush, id_ex_flush, halted, stall_cnt
  );

  modport slave (
    input  id_srcReg1, id_srcReg2, id_uses_src1, id_uses_src2, id_hlt,
           ex_dstReg, ex_memRead, ex_br_taken, mem_busy,
    output pc_wen, if_id_wen, id_ex_wen, ex_mem_wen, mem_wb_wen,
           if_id_flush, id_ex_flush, halted, stall_cnt
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, branch
// redirects, memory freezes, HLT drain and a saturating stall counter.
module pipeline_hazard_ctrl #(
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  pipeline_hazard_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

  state_t           state_q, state_d;
  logic [2:0]       drain_q, drain_d;
  logic [CNT_W-1:0] cnt_q;
  logic             lu;
  logic             pc_w, ifid_w, idex_w, exmem_w, memwb_w;
  logic             ifid_f, idex_f, halt_o;

  // R0 is hardwired zero, so a load targeting it can never create a hazard
  assign lu = bus.ex_memRead && (bus.ex_dstReg != 4'd0) &&
              ((bus.id_uses_src1 && (bus.id_srcReg1 == bus.ex_dstReg)) ||
               (bus.id_uses_src2 && (bus.id_srcReg2 == bus.ex_dstReg)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      drain_q <= 3'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      if ((state_q != HALTED) && !pc_w && (cnt_q != {CNT_W{1'b1}}))
        cnt_q <= cnt_q + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    pc_w    = 1'b1;
    ifid_w  = 1'b1;
    idex_w  = 1'b1;
    exmem_w = 1'b1;
    memwb_w = 1'b1;
    ifid_f  = 1'b0;
    idex_f  = 1'b0;
    halt_o  = 1'b0;
    case (state_q)
      RUN: begin
        if (bus.mem_busy) begin
          {pc_w, ifid_w, idex_w, exmem_w, memwb_w} = 5'b00000;
        end else if (bus.ex_br_taken) begin
          ifid_f = 1'b1;
          idex_f = 1'b1;
        end else if (lu || bus.id_hlt) begin
          pc_w   = 1'b0;
          ifid_w = 1'b0;
          idex_f = 1'b1;
          // A coincident load-use wins; HLT is picked up on the retry cycle
          if (!lu) begin
            state_d = DRAIN;
            drain_d = 3'(DRAIN_CYCLES - 1);
          end
        end
      end
      DRAIN: begin
        if (bus.mem_busy) begin
          {pc_w, ifid_w, idex_w, exmem_w, memwb_w} = 5'b00000;
        end else if (bus.ex_br_taken) begin
          ifid_f  = 1'b1;
          idex_f  = 1'b1;
          state_d = RUN;
        end else begin
          pc_w   = 1'b0;
          ifid_w = 1'b0;
          idex_f = 1'b1;
          if (drain_q == 3'd0) state_d = HALTED;
          else                 drain_d = drain_q - 3'd1;
        end
      end
      HALTED: begin
        {pc_w, ifid_w, idex_w, exmem_w, memwb_w} = 5'b00000;
        halt_o = 1'b1;
      end
      default: state_d = RUN;
    endcase
  end

  assign bus.pc_wen      = rst_n & pc_w;
  assign bus.if_id_wen   = rst_n & ifid_w;
  assign bus.id_ex_wen   = rst_n & idex_w;
  assign bus.ex_mem_wen  = rst_n & exmem_w;
  assign bus.mem_wb_wen  = rst_n & memwb_w;
  assign bus.if_id_flush = rst_n & ifid_f;
  assign bus.id_ex_flush = rst_n & idex_f;
  assign bus.halted      = rst_n & halt_o;
  assign bus.stall_cnt   = cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench: directed scenarios then random traffic, checked against a
// rule-level reference model; a second instance exercises 4-bit saturation.
module tb_pipeline_hazard_ctrl;

  localparam int DRAIN = 3;
  localparam logic [6:0] ALL_ON = 7'b1111100;
  localparam logic [6:0] STALL  = 7'b0011101;
  localparam logic [6:0] BRANCH = 7'b1111111;
  localparam logic [6:0] FREEZE = 7'b0000000;

  typedef struct {
    logic [6:0] ctrl;
    logic       halted;
    int         cnt_a;
    int         cnt_b;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   done = 1'b0;

  bit   m_halted, m_draining;
  int   m_left, m_cnt_a, m_cnt_b;

  pipeline_hazard_ctrl_if #(.CNT_W(16)) bus_a ();
  pipeline_hazard_ctrl_if #(.CNT_W(4))  bus_b ();

  pipeline_hazard_ctrl #(.DRAIN_CYCLES(DRAIN), .CNT_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a));
  pipeline_hazard_ctrl #(.DRAIN_CYCLES(DRAIN), .CNT_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b));

  assign bus_b.id_srcReg1   = bus_a.id_srcReg1;
  assign bus_b.id_srcReg2   = bus_a.id_srcReg2;
  assign bus_b.id_uses_src1 = bus_a.id_uses_src1;
  assign bus_b.id_uses_src2 = bus_a.id_uses_src2;
  assign bus_b.id_hlt       = bus_a.id_hlt;
  assign bus_b.ex_dstReg    = bus_a.ex_dstReg;
  assign bus_b.ex_memRead   = bus_a.ex_memRead;
  assign bus_b.ex_br_taken  = bus_a.ex_br_taken;
  assign bus_b.mem_busy     = bus_a.mem_busy;

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %0d expected %0d", name, $time, actual, expected);
    end
  endtask

  // One cycle of stimulus: drive at the falling edge, predict this cycle's
  // outputs from the rules, then advance the model past the next rising edge.
  task automatic applyStimulus(input bit r, input int s1, input int s2, input bit u1,
                               input bit u2, input bit hlt, input int dst,
                               input bit mr, input bit br, input bit busy);
    exp_t e;
    bit   hazard, was_halted;
    @(negedge clk);
    rst_n               = r;
    bus_a.id_srcReg1    = 4'(s1);
    bus_a.id_srcReg2    = 4'(s2);
    bus_a.id_uses_src1  = u1;
    bus_a.id_uses_src2  = u2;
    bus_a.id_hlt        = hlt;
    bus_a.ex_dstReg     = 4'(dst);
    bus_a.ex_memRead    = mr;
    bus_a.ex_br_taken   = br;
    bus_a.mem_busy      = busy;
    e.halted = 1'b0;
    if (!r) begin
      m_halted = 0; m_draining = 0; m_left = 0; m_cnt_a = 0; m_cnt_b = 0;
      e.ctrl = FREEZE; e.cnt_a = 0; e.cnt_b = 0;
      exp_q.push_back(e);
      return;
    end
    e.cnt_a = m_cnt_a;
    e.cnt_b = m_cnt_b;
    hazard = mr && (dst != 0) && ((u1 && s1 == dst) || (u2 && s2 == dst));
    was_halted = m_halted;
    if (m_halted) begin
      e.ctrl = FREEZE;
      e.halted = 1'b1;
    end else if (busy) begin
      e.ctrl = FREEZE;
    end else if (br) begin
      e.ctrl = BRANCH;
      m_draining = 0;
    end else if (m_draining) begin
      e.ctrl = STALL;
      m_left--;
      if (m_left == 0) begin
        m_draining = 0;
        m_halted = 1;
      end
    end else if (hazard) begin
      e.ctrl = STALL;
    end else if (hlt) begin
      e.ctrl = STALL;
      m_draining = 1;
      m_left = DRAIN;
    end else begin
      e.ctrl = ALL_ON;
    end
    if (!was_halted && !e.ctrl[6]) begin
      if (m_cnt_a < 65535) m_cnt_a++;
      if (m_cnt_b < 15) m_cnt_b++;
    end
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic loadUse(input bit br, input bit busy, input int dst);
    applyStimulus(1, 1, dst, 0, 1, 0, dst, 1, br, busy);
  endtask

  // Monitor: outputs are valid every cycle, so compare once per cycle just
  // before the rising edge against whatever the driver queued.
  initial begin
    exp_t e;
    logic [6:0] act;
    forever begin
      @(negedge clk);
      #2;
      if (done) break;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        act = {bus_a.pc_wen, bus_a.if_id_wen, bus_a.id_ex_wen, bus_a.ex_mem_wen,
               bus_a.mem_wb_wen, bus_a.if_id_flush, bus_a.id_ex_flush};
        checkOutput("ctrl", int'(act), int'(e.ctrl));
        checkOutput("halted", int'(bus_a.halted), int'(e.halted));
        checkOutput("stall_cnt16", int'(bus_a.stall_cnt), e.cnt_a);
        checkOutput("stall_cnt4", int'(bus_b.stall_cnt), e.cnt_b);
        checkOutput("ctrl_b", int'({bus_b.pc_wen, bus_b.id_ex_flush}),
                    int'({e.ctrl[6], e.ctrl[0]}));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus_a.id_srcReg1 = 0; bus_a.id_srcReg2 = 0; bus_a.id_uses_src1 = 0;
    bus_a.id_uses_src2 = 0; bus_a.id_hlt = 0; bus_a.ex_dstReg = 0;
    bus_a.ex_memRead = 0; bus_a.ex_br_taken = 0; bus_a.mem_busy = 0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #3 checkOutput("reset_pc_wen", int'(bus_a.pc_wen), 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(1);

    loadUse(0, 0, 5);
    idle(1);
    #3 checkOutput("lu_count", int'(bus_a.stall_cnt), 1);
    loadUse(0, 0, 0);
    idle(1);
    #3 checkOutput("r0_no_stall", int'(bus_a.stall_cnt), 1);
    loadUse(1, 0, 5);
    idle(1);
    #3 checkOutput("branch_no_count", int'(bus_a.stall_cnt), 1);

    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) loadUse(0, 1, 5);
    loadUse(0, 0, 5);
    idle(1);
    #3 checkOutput("freeze_count", int'(bus_a.stall_cnt), 5);

    applyStimulus(1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    idle(DRAIN);
    idle(1);
    #3 checkOutput("halted_after_drain", int'(bus_a.halted), 1);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    #3 checkOutput("halted_ignores_branch", int'(bus_a.pc_wen), 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #3 checkOutput("reset_clears_halt", int'(bus_a.halted), 0);

    idle(1);
    applyStimulus(1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    idle(1);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    idle(1);
    #3 checkOutput("wrong_path_run", int'(bus_a.pc_wen), 1);
    idle(4);
    #3 checkOutput("wrong_path_never_halts", int'(bus_a.halted), 0);

    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) loadUse(0, 0, 7);
    idle(1);
    #3 checkOutput("sat_cnt4", int'(bus_b.stall_cnt), 15);
    #0 checkOutput("unsat_cnt16", int'(bus_a.stall_cnt), 20);

    for (int i = 0; i < 3000; i++) begin
      applyStimulus($urandom_range(0, 39) != 0,
                    $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                    $urandom_range(0, 24) == 0, $urandom_range(0, 3),
                    $urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0,
                    $urandom_range(0, 7) == 0);
    end

    @(negedge clk);
    #4;
    done = 1'b1;
    checkOutput("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
